seq_restoring_divider_32bit: RTL and testbench
==============================================

Name: seq_restoring_divider_32bit

Overview:
Multi-cycle unsigned integer divider for the ALU's DIV/MOD path. It is the inverse datapath of the lookahead adder: it performs one shift-and-subtract step per clock using a lookahead subtractor. It takes a start request, iterates WIDTH cycles, and returns quotient and remainder with a one-cycle done pulse. The control FSM stalls the pipeline on busy.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only when ready=1
dividend  input  WIDTH  unsigned dividend; captured on an accepted start
divisor  input  WIDTH  unsigned divisor; captured on an accepted start
ready  output  1  high in IDLE and DONE; start is accepted this cycle
busy  output  1  high while iterating (RUN)
done  output  1  single-cycle pulse; results valid this cycle and held afterward
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  set with done when the captured divisor==0; held with results

Behaviour:
- Reset (rst=1 at edge): state=IDLE, count=0, internal regs=0, quotient=0, remainder=0, done=0, div_by_zero=0, busy=0, ready=1. Reset takes priority over everything, including mid-RUN; the in-flight division is discarded and no done is issued.
- States (2-bit): IDLE=00, RUN=01, DONE=10; 11 is illegal and recovers to IDLE.
- IDLE: on start=1, capture Q<=dividend, D<=divisor, R<=0 (WIDTH+1 bits), count<=WIDTH, clear div_by_zero.
  - If divisor==0, go to DONE.
  - Otherwise go to RUN.
- RUN, one step per cycle:
  - Form shifted = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Form diff = shifted - {0,D}, computed as shifted + ~{0,D} + 1 via the lookahead subtractor.
  - If diff[WIDTH]==0 (no borrow), R<=diff and Q<={Q[WIDTH-2:0],1}.
  - Else R<=shifted and Q<={Q[WIDTH-2:0],0}.
  - Decrement count. When count reaches 1 on this step, next state is DONE.
  - start is ignored in RUN; the captured operands are not affected by input changes.
- DONE (one cycle): done=1.
  - Normal case: quotient=Q, remainder=R[WIDTH-1:0].
  - Divide-by-zero: quotient=all ones, remainder=captured dividend, div_by_zero=1.
  - If start=1 in DONE, accept new operands as in IDLE (back-to-back); otherwise go to IDLE.
- Outputs quotient, remainder and div_by_zero are registered. They hold their last values through IDLE and are overwritten only at the next DONE or at reset.
- Latency: start accepted at edge T0.
  - Normal: done is high in the cycle after edge T0+WIDTH, i.e. WIDTH+1 cycles (33 for WIDTH=32).
  - Divide-by-zero: 1 cycle.
- Edge operands:
  - dividend < divisor gives q=0, r=dividend.
  - dividend==0 gives q=0, r=0 after the full WIDTH cycles.
  - The R register is WIDTH+1 bits so no overflow is possible for divisor >= 2^(WIDTH-1).

Decomposition:
- Shared package/header: state encodings (IDLE/RUN/DONE), default WIDTH=32 and CNT_W=6, and the div-by-zero quotient constant (all ones).
- One sub-module, div_step_subtractor: a (WIDTH+1)-bit a - b built from the existing 2-bit lookahead units, outputting diff and the borrow (MSB).
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- rst, then start with dividend=100, divisor=7 -> busy for 32 cycles; done pulse 33 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=0xFFFFFFFF, divisor=0x80000000 -> quotient=1, remainder=0x7FFFFFFF.
- dividend=5, divisor=0 -> done one cycle after accept; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. div_by_zero clears on the next accepted start.
- Start 50/9, then toggle start and change operands during RUN -> ignored; result is 5 r 5. Assert start with 81/9 in the DONE cycle -> accepted back-to-back; 9 r 0 after 33 more cycles.
- Start 1000/3, assert rst at cycle 10 of RUN -> next cycle IDLE, all outputs 0, no done pulse. A fresh 1000/3 gives 333 r 1.
- dividend=3, divisor=10 -> quotient=0, remainder=3. Outputs hold their values for 5 idle cycles after done.

Source files
------------

// File: rtl/seq_restoring_divider_32bit_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - DefWidth / DefCntW : default operand width and iteration counter width
//   - div_state_e        : control FSM state encoding (11 is illegal, recovers to idle)
//   - DbzFill            : fill bit of the quotient reported on divide-by-zero (all ones)
package seq_restoring_divider_32bit_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefCntW  = 6;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } div_state_e;

    // Replicated across the full quotient width on divide-by-zero.
    localparam logic DbzFill = 1'b1;

endpackage

// File: rtl/seq_restoring_divider_32bit_div_step_subtractor.sv
// One shift-and-subtract step subtractor: diff = a - b = a + ~b + 1, built as a
// ripple of 2-bit carry-lookahead units (the last unit is 1 bit wide for odd widths).
// Ports:
//   a_i      : minuend
//   b_i      : subtrahend
//   diff_o   : a - b modulo 2^Width
//   borrow_o : MSB of diff; set when a < b for the divider's operand ranges
module seq_restoring_divider_32bit_div_step_subtractor #(
    parameter int unsigned Width = 33
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] diff_o,
    output logic             borrow_o
);

    localparam int unsigned NumUnits = (Width + 1) / 2;

    logic [Width-1:0]    b_inv;
    logic [Width-1:0]    p;
    // The top bit's generate term is never needed: no carry leaves the top unit.
    logic [Width-2:0]    g;
    logic [NumUnits-1:0] carry;

    assign b_inv    = ~b_i;
    assign p        = a_i ^ b_inv;
    assign g        = a_i[Width-2:0] & b_inv[Width-2:0];
    // The +1 of two's complement enters as the carry into the first unit.
    assign carry[0] = 1'b1;

    for (genvar u = 0; u < NumUnits; u++) begin : g_unit
        localparam int unsigned Lo = 2 * u;

        assign diff_o[Lo] = p[Lo] ^ carry[u];

        if (Lo + 1 < Width) begin : g_hi
            logic c_mid;
            assign c_mid          = g[Lo] | (p[Lo] & carry[u]);
            assign diff_o[Lo + 1] = p[Lo + 1] ^ c_mid;

            if (u + 1 < NumUnits) begin : g_cout
                // Lookahead carry-out of the 2-bit group, not rippled through c_mid.
                assign carry[u + 1] = g[Lo + 1]
                                    | (p[Lo + 1] & g[Lo])
                                    | (p[Lo + 1] & p[Lo] & carry[u]);
            end
        end
    end

    assign borrow_o = diff_o[Width-1];

endmodule

// File: rtl/seq_restoring_divider_32bit.sv
// Multi-cycle unsigned restoring divider (one shift-and-subtract step per clock).
// Ports:
//   clk_i         : clock, all state updates on the rising edge
//   rst_i         : synchronous active-high reset, aborts any division in flight
//   start_i       : division request, taken only while ready_o is high
//   dividend_i    : dividend, captured on an accepted start
//   divisor_i     : divisor, captured on an accepted start
//   ready_o       : high in idle and done; a start this cycle is accepted
//   busy_o        : high while iterating
//   done_o        : one-cycle pulse when results become valid
//   quotient_o    : quotient, held until the next done or reset
//   remainder_o   : remainder, held until the next done or reset
//   div_by_zero_o : set with done when the divisor was zero, held with the results
module seq_restoring_divider_32bit
    import seq_restoring_divider_32bit_pkg::*;
#(
    parameter int unsigned Width = DefWidth,
    parameter int unsigned CntW  = DefCntW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o,
    output logic             div_by_zero_o
);

    div_state_e       state_q;
    logic [CntW-1:0]  count_q;
    logic [Width-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [Width-1:0] d_q;      // captured divisor
    logic [Width:0]   r_q;      // partial remainder, one spare bit of headroom
    logic [Width-1:0] quot_q;
    logic [Width-1:0] rem_q;
    logic             dbz_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic [Width:0]   shifted_d;
    logic [Width:0]   diff_d;
    logic             borrow_d;
    logic [Width:0]   r_d;
    logic [Width-1:0] q_d;

    // Restoring only ever stores values below the divisor, so the spare MSB stays clear.
    logic unused_r_msb;
    assign unused_r_msb = r_q[Width];

    seq_restoring_divider_32bit_div_step_subtractor #(
        .Width (Width + 1)
    ) u_step_sub (
        .a_i      (shifted_d),
        .b_i      ({1'b0, d_q}),
        .diff_o   (diff_d),
        .borrow_o (borrow_d)
    );

    always_comb begin
        shifted_d = {r_q[Width-1:0], q_q[Width-1]};
        // Keep the difference when it did not go negative, otherwise restore.
        r_d       = borrow_d ? shifted_d : diff_d;
        q_d       = {q_q[Width-2:0], ~borrow_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        q_q     <= dividend_i;
                        d_q     <= divisor_i;
                        r_q     <= '0;
                        count_q <= CntW'(Width);
                        if (divisor_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            quot_q  <= {Width{DbzFill}};
                            rem_q   <= dividend_i;
                            dbz_q   <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StRun;
                            dbz_q   <= 1'b0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q - CntW'(1);
                    // Final step: publish the results so they are valid in the done cycle.
                    if (count_q == CntW'(1)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= r_d[Width-1:0];
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o       = ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider_32bit.sv
// Self-checking bench for seq_restoring_divider_32bit: a transaction-level model
// (plain / and % with a cycle countdown) checked against the DUT every cycle, plus
// hand-computed literal results for directed vectors.
module tb_seq_restoring_divider_32bit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    seq_restoring_divider_32bit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .ready_o       (ready),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: a job finishes W clocks after acceptance; divide-by-zero
    // finishes on the accepting clock.
    bit           mdl_valid = 1'b0;
    bit           pend = 1'b0;
    int           remaining = 0;
    logic [W-1:0] pend_q = '0;
    logic [W-1:0] pend_r = '0;
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    bit           exp_z = 1'b0;
    bit           exp_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mdl_valid = 1'b1;
            pend      = 1'b0;
            remaining = 0;
            exp_q     = '0;
            exp_r     = '0;
            exp_z     = 1'b0;
            exp_done  = 1'b0;
        end else if (mdl_valid) begin
            exp_done = 1'b0;
            if (pend) begin
                remaining--;
                if (remaining == 0) begin
                    pend     = 1'b0;
                    exp_done = 1'b1;
                    exp_q    = pend_q;
                    exp_r    = pend_r;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    exp_done = 1'b1;
                    exp_q    = '1;
                    exp_r    = dividend;
                    exp_z    = 1'b1;
                end else begin
                    pend      = 1'b1;
                    remaining = W;
                    pend_q    = dividend / divisor;
                    pend_r    = dividend % divisor;
                    exp_z     = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("done", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(pend));
            check("ready", 32'(ready), 32'(!pend));
            check("quotient", quotient, exp_q);
            check("remainder", remainder, exp_r);
            check("div_by_zero", 32'(div_by_zero), 32'(exp_z));
        end
    end

    // Called at a negedge: drive a start for exactly one clock.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; the latency counted from one clock after acceptance is checked.
    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] q,
                                 input logic [W-1:0] r, input logic z);
        check({name, " q"}, quotient, q);
        check({name, " r"}, remainder, r);
        check({name, " dbz"}, 32'(div_by_zero), 32'(z));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        @(negedge clk);
        @(negedge clk);
        check("reset ready", 32'(ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        expect_result("reset", 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        do_start(32'd100, 32'd7);
        wait_done("100/7", 32);
        expect_result("100/7", 32'd14, 32'd2, 1'b0);
        @(negedge clk);

        do_start(32'hFFFF_FFFF, 32'd1);
        wait_done("max/1", 32);
        expect_result("max/1", 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk);

        do_start(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("max/msb", 32);
        expect_result("max/msb", 32'd1, 32'h7FFF_FFFF, 1'b0);
        @(negedge clk);

        do_start(32'd0, 32'd7);
        wait_done("0/7", 32);
        expect_result("0/7", 32'd0, 32'd0, 1'b0);
        @(negedge clk);

        do_start(32'd5, 32'd0);
        wait_done("5/0", 0);
        expect_result("5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);

        // Back-to-back from the divide-by-zero done cycle; the flag clears on accept.
        do_start(32'd3, 32'd10);
        check("dbz cleared", 32'(div_by_zero), 32'd0);
        wait_done("3/10", 32);
        expect_result("3/10", 32'd0, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        check("hold done", 32'(done), 32'd0);
        expect_result("3/10 hold", 32'd0, 32'd3, 1'b0);

        // Inputs wiggling during RUN must not disturb the division.
        do_start(32'd50, 32'd9);
        for (int i = 0; i < 6; i++) begin
            start    = ~start;
            dividend = 32'(1000 + i);
            divisor  = 32'(i);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("50/9", 26);
        expect_result("50/9", 32'd5, 32'd5, 1'b0);
        do_start(32'd81, 32'd9);
        wait_done("81/9", 32);
        expect_result("81/9", 32'd9, 32'd0, 1'b0);
        @(negedge clk);

        // Reset mid-run discards the job.
        do_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort ready", 32'(ready), 32'd1);
        expect_result("abort", 32'd0, 32'd0, 1'b0);
        seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);

        do_start(32'd1000, 32'd3);
        wait_done("1000/3", 32);
        expect_result("1000/3", 32'd333, 32'd1, 1'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
